// File: rtl/cpu_multicycle_seq_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: opcodes, ALU ops, FSM states.
package cpu_ctrl_pkg;

    localparam int OPW    = 4;
    localparam int ALUOPW = 2;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b1001;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_BEQ   = 4'b1100;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_FN  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/cpu_multicycle_seq_if.sv
// Shared single-port memory handshake between the sequencer (master) and memory (slave).
interface cpu_multicycle_seq_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/cpu_multicycle_seq_op_class.sv
// Opcode classifier: splits an opcode into the categories the sequencer branches on.
module cpu_op_class
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW_P = OPW
) (
    input  logic [OPW_P-1:0] op_i,
    output logic             legal_o,
    output logic             is_alu_o,
    output logic             is_mem_o,
    output logic             is_store_o,
    output logic             is_branch_o,
    output logic             is_halt_o
);
    // Pure decode; legal covers every opcode with a defined execution path.
    always_comb begin
        is_alu_o    = (op_i == OP_TYPEA) || (op_i == OP_ANDI) || (op_i == OP_ORI);
        is_mem_o    = (op_i == OP_LBU) || (op_i == OP_SB);
        is_store_o  = (op_i == OP_SB);
        is_branch_o = (op_i == OP_BEQ);
        is_halt_o   = (op_i == OP_HALT);
        legal_o     = is_alu_o || is_mem_o || is_branch_o || is_halt_o;
    end
endmodule

// File: rtl/cpu_multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and sticky error.
// Optional macro PERF_CNT_EN adds instr_cnt/stall_cnt performance counters.
module cpu_multicycle_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW_P       = OPW,
    parameter int ALUOPW_P    = ALUOPW,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt_req,
    input  logic [OPW_P-1:0]    ir_opcode,
    input  logic                alu_zero,
    cpu_multicycle_seq_if.master mem,
    output logic                pc_write,
    output logic                pc_src,
    output logic                ir_write,
    output logic                alu_src,
    output logic [ALUOPW_P-1:0] alu_op,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                r15_sel,
    output logic                busy,
    output logic                instr_done,
    output logic                err
`ifdef PERF_CNT_EN
    ,
    output logic [15:0]         instr_cnt,
    output logic [15:0]         stall_cnt
`endif
);
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_e           state_q;
    logic [OPW_P-1:0] op_q;
    logic [7:0]       wait_cnt_q;
    logic [OPW_P-1:0] cls_op;
    logic             legal, is_alu, is_mem, is_store, is_branch, is_halt;
    logic             mem_wait;
    state_e           retire_d;

    // op_q only becomes valid after DECODE, so DECODE classifies the live IR field.
    assign cls_op   = (state_q == S_DECODE) ? ir_opcode : op_q;
    assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem.mem_ready;
    assign retire_d = halt_req ? S_IDLE : S_FETCH;

    cpu_op_class #(.OPW_P(OPW_P)) u_cls (
        .op_i        (cls_op),
        .legal_o     (legal),
        .is_alu_o    (is_alu),
        .is_mem_o    (is_mem),
        .is_store_o  (is_store),
        .is_branch_o (is_branch),
        .is_halt_o   (is_halt)
    );

    // Control decode from state/op_q; strobes that complete a handshake are qualified by mem_ready/alu_zero.
    always_comb begin
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        ir_write         = 1'b0;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        alu_src          = 1'b0;
        alu_op           = '0;
        reg_write        = 1'b0;
        mem_to_reg       = 1'b0;
        r15_sel          = 1'b0;
        instr_done       = 1'b0;
        err              = (state_q == S_ERR);
        busy             = (state_q != S_IDLE);
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ir_write    = mem.mem_ready;
                pc_write    = mem.mem_ready;
            end
            S_DECODE: instr_done = is_halt;
            S_EXEC: begin
                case (op_q)
                    OP_TYPEA: alu_op = ALU_FN;
                    OP_ANDI:  begin alu_src = 1'b1; alu_op = ALU_FN;  end
                    OP_ORI:   begin alu_src = 1'b1; alu_op = ALU_OR;  end
                    OP_LBU,
                    OP_SB:    begin alu_src = 1'b1; alu_op = ALU_ADD; end
                    OP_BEQ: begin
                        alu_op     = ALU_SUB;
                        pc_write   = alu_zero;
                        pc_src     = alu_zero;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = is_store;
                instr_done       = is_store && mem.mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q != OP_LBU);
                r15_sel    = (op_q == OP_TYPEA);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer state, latched opcode and memory wait counter; ready beats the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) state_q <= S_FETCH;
                S_FETCH, S_MEM: begin
                    if (mem.mem_ready) begin
                        wait_cnt_q <= '0;
                        if (state_q == S_FETCH) state_q <= S_DECODE;
                        else if (is_store)      state_q <= retire_d;
                        else                    state_q <= S_WB;
                    end else if (wait_cnt_q == TMO) begin
                        wait_cnt_q <= '0;
                        state_q    <= S_ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    op_q <= ir_opcode;
                    if (is_halt)    state_q <= S_IDLE;
                    else if (legal) state_q <= S_EXEC;
                    else            state_q <= S_ERR;
                end
                S_EXEC: begin
                    if (is_branch)   state_q <= retire_d;
                    else if (is_mem) state_q <= S_MEM;
                    else if (is_alu) state_q <= S_WB;
                    else             state_q <= S_ERR;
                end
                S_WB:    state_q <= retire_d;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] instr_cnt_q, stall_cnt_q;

    // Free-running retire and memory-stall counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (instr_done) instr_cnt_q <= instr_cnt_q + 16'd1;
            if (mem_wait)   stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_mem_wait;
    assign unused_mem_wait = mem_wait;
`endif

endmodule

// File: tb/tb_cpu_multicycle_seq.sv
// Scoreboard bench for cpu_multicycle_seq: stimulus pushes per-cycle expected controls,
// a negedge monitor pops and compares whenever the sequencer is busy or retiring.
module tb_cpu_multicycle_seq;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel, alu_src;
        logic [1:0] alu_op;
        logic       reg_write, mem_to_reg, r15_sel, busy, instr_done, err;
    } ctl_t;

    logic clk = 1'b0, rst = 1'b0;
    logic start = 1'b0, halt_req = 1'b0, alu_zero = 1'b0;
    logic [3:0] ir_opcode = 4'h5;
    logic pc_write, pc_src, ir_write, alu_src, reg_write, mem_to_reg, r15_sel;
    logic busy, instr_done, err;
    logic [1:0] alu_op;
`ifdef PERF_CNT_EN
    logic [15:0] instr_cnt, stall_cnt;
    int exp_instr = 0, exp_stall = 0;
`endif

    cpu_multicycle_seq_if mif ();

    cpu_multicycle_seq #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .ir_opcode(ir_opcode), .alu_zero(alu_zero), .mem(mif),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .r15_sel(r15_sel), .busy(busy),
        .instr_done(instr_done), .err(err)
`ifdef PERF_CNT_EN
        , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    ctl_t act;
    assign act = {pc_write, pc_src, ir_write, mif.mem_req, mif.mem_we, mif.mem_addr_sel,
                  alu_src, alu_op, reg_write, mem_to_reg, r15_sel, busy, instr_done, err};

    ctl_t sb[$];
    int   checks = 0, errors = 0, cyc_no = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Expected-control builders
    function automatic ctl_t c_fetch(input bit rdy);
        ctl_t c = '0;
        c.busy = 1; c.mem_req = 1; c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction
    function automatic ctl_t c_decode(input bit halt);
        ctl_t c = '0;
        c.busy = 1; c.instr_done = halt;
        return c;
    endfunction
    function automatic ctl_t c_exec(input bit src, input logic [1:0] op, input bit taken, input bit done);
        ctl_t c = '0;
        c.busy = 1; c.alu_src = src; c.alu_op = op;
        c.pc_write = taken; c.pc_src = taken; c.instr_done = done;
        return c;
    endfunction
    function automatic ctl_t c_mem(input bit we, input bit rdy);
        ctl_t c = '0;
        c.busy = 1; c.mem_req = 1; c.mem_addr_sel = 1; c.mem_we = we; c.instr_done = we & rdy;
        return c;
    endfunction
    function automatic ctl_t c_wb(input bit m2r, input bit r15);
        ctl_t c = '0;
        c.busy = 1; c.reg_write = 1; c.mem_to_reg = m2r; c.r15_sel = r15; c.instr_done = 1;
        return c;
    endfunction
    function automatic ctl_t c_err();
        ctl_t c = '0;
        c.busy = 1; c.err = 1;
        return c;
    endfunction

    // Monitor: one expected entry per busy/retiring cycle
    always @(negedge clk) begin
        if (busy || instr_done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ctl: got %h expected none (t=%0t)", act, $time);
            end else begin
                chk("ctl", 32'(act), 32'(sb.pop_front()));
            end
        end
    end

    // One sequencer cycle: drive inputs just after the edge, queue the expected controls
    task automatic cyc(input bit rdy, input logic [3:0] op, input bit z, input bit h, input ctl_t exp);
        mif.mem_ready = rdy; ir_opcode = op; alu_zero = z; halt_req = h;
        sb.push_back(exp);
`ifdef PERF_CNT_EN
        if (exp.mem_req && !rdy) exp_stall++;
        if (exp.instr_done)      exp_instr++;
`endif
        cyc_no++;
        @(posedge clk); #1;
    endtask

    task automatic go();
        start = 1'b1; mif.mem_ready = 1'b1; halt_req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_chk(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
`ifdef PERF_CNT_EN
        chk({name, "_instr_cnt"}, 32'(instr_cnt), 32'(exp_instr));
        chk({name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
`endif
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        #1 chk({name, "_async_zero"}, 32'(act), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk({name, "_held_zero"}, 32'(act), 32'd0);
        rst = 1'b1;
`ifdef PERF_CNT_EN
        exp_instr = 0; exp_stall = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.mem_ready = 1'b0;
        #1 chk("reset_ctl", 32'(act), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_ctl_held", 32'(act), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        idle_chk("post_reset");

        // TypeA -> ANDI -> ORI back to back, halt on the last retire
        go();
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_TYPEA, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 0, c_exec(0, ALU_FN, 0, 0));
        cyc(1, 4'h5, 0, 0, c_wb(1, 1));
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_ANDI, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 0, c_exec(1, ALU_FN, 0, 0));
        cyc(1, 4'h5, 0, 0, c_wb(1, 0));
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_ORI, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 0, c_exec(1, ALU_OR, 0, 0));
        cyc(1, 4'h5, 0, 1, c_wb(1, 0));
        idle_chk("alu_seq");

        // LBU: two FETCH wait states, three MEM wait states
        go();
        cyc(0, 4'h5, 0, 0, c_fetch(0));
        cyc(0, 4'h5, 0, 0, c_fetch(0));
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_LBU, 0, 0, c_decode(0));
        cyc(0, 4'h5, 0, 0, c_exec(1, ALU_ADD, 0, 0));
        cyc(0, 4'h5, 0, 0, c_mem(0, 0));
        cyc(0, 4'h5, 0, 0, c_mem(0, 0));
        cyc(0, 4'h5, 0, 0, c_mem(0, 0));
        cyc(1, 4'h5, 0, 0, c_mem(0, 1));
        cyc(1, 4'h5, 0, 1, c_wb(0, 0));
        idle_chk("lbu");

        // BEQ taken then not taken; halt_req outside retire is ignored
        go();
        cyc(1, 4'h5, 0, 1, c_fetch(1));
        cyc(1, OP_BEQ, 0, 1, c_decode(0));
        cyc(1, 4'h5, 1, 0, c_exec(0, ALU_SUB, 1, 1));
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_BEQ, 1, 0, c_decode(0));
        cyc(1, 4'h5, 0, 1, c_exec(0, ALU_SUB, 0, 1));
        idle_chk("beq");

        // SB with halt_req on the retiring MEM cycle
        go();
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_SB, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 0, c_exec(1, ALU_ADD, 0, 0));
        cyc(0, 4'h5, 0, 1, c_mem(1, 0));
        cyc(1, 4'h5, 0, 1, c_mem(1, 1));
        idle_chk("sb_halt");

        // mem_ready arrives on the timeout cycle, then HALT opcode retires in DECODE
        go();
        for (int i = 0; i < 15; i++) cyc(0, 4'h5, 0, 0, c_fetch(0));
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_HALT, 0, 0, c_decode(1));
        idle_chk("tmo_edge_halt");
        chk("tmo_edge_no_err", 32'(err), 32'd0);

        // Illegal opcode -> sticky ERR, start ignored
        go();
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, 4'h5, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 1, c_err());
        start = 1'b1;
        cyc(1, OP_TYPEA, 1, 0, c_err());
        start = 1'b0;
        cyc(0, 4'h5, 0, 0, c_err());
        do_reset("rst_illegal");
        @(posedge clk); #1;
        idle_chk("after_illegal");

        // FETCH timeout: 16 cycles without ready -> ERR
        go();
        for (int i = 0; i < 16; i++) cyc(0, 4'h5, 0, 0, c_fetch(0));
        cyc(1, 4'h5, 0, 0, c_err());
        cyc(1, 4'h5, 0, 0, c_err());
        do_reset("rst_tmo");
        @(posedge clk); #1;
        idle_chk("after_tmo");

        // Reset pulled mid-MEM, then a fresh instruction runs
        go();
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_LBU, 0, 0, c_decode(0));
        cyc(1, 4'h5, 0, 0, c_exec(1, ALU_ADD, 0, 0));
        cyc(0, 4'h5, 0, 0, c_mem(0, 0));
        mif.mem_ready = 1'b0;
        do_reset("rst_mem");
        @(posedge clk); #1;
        idle_chk("after_rst_mem");
        go();
        cyc(1, 4'h5, 0, 0, c_fetch(1));
        cyc(1, OP_HALT, 0, 0, c_decode(1));
        idle_chk("restart");

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
